// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX transmit framer.
package fix_pkg;

  typedef enum logic [2:0] {
    S_LOAD, S_HDR, S_LEN, S_LDLM, S_BODY, S_TRL, S_CKS, S_TDLM
  } fix_state_t;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_1  = 8'h31;
  localparam logic [7:0] ASC_8  = 8'h38;
  localparam logic [7:0] ASC_9  = 8'h39;
  localparam logic [7:0] ASC_EQ = 8'h3d;

  localparam int unsigned HDR_LEN       = 10;
  localparam logic [7:0]  DELIM_DEFAULT = 8'h3b;

  // Bytes of "8=FIX.4.<m><D>"; the "9=" tag is emitted at the start of LEN.
  function automatic logic [7:0] hdr_byte(input logic [3:0] i, input logic [3:0] minor,
                                          input logic [7:0] delim);
    case (i)
      4'd0:    hdr_byte = ASC_8;
      4'd1:    hdr_byte = ASC_EQ;
      4'd2:    hdr_byte = 8'h46;
      4'd3:    hdr_byte = 8'h49;
      4'd4:    hdr_byte = 8'h58;
      4'd5:    hdr_byte = 8'h2e;
      4'd6:    hdr_byte = 8'h34;
      4'd7:    hdr_byte = 8'h2e;
      4'd8:    hdr_byte = {4'h3, minor};
      default: hdr_byte = delim;
    endcase
  endfunction

endpackage

// File: rtl/fix_bin2dec.sv
// Combinational 10-bit binary to three decimal digits plus significant digit count.
module fix_bin2dec
  import fix_pkg::*;
(
  input  logic [9:0] value,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [1:0] ndig
);

  always_comb begin
    d2   = 4'(value / 10'd100);
    d1   = 4'((value / 10'd10) % 10'd10);
    d0   = 4'(value % 10'd10);
    ndig = (value >= 10'd100) ? 2'd3 : ((value >= 10'd10) ? 2'd2 : 2'd1);
  end

endmodule

// File: rtl/fix_msg_tx.sv
// Outbound FIX framer: buffers a message body, then emits header, BodyLength, body and CheckSum.
module fix_msg_tx
  import fix_pkg::*;
#(
  parameter int unsigned BODY_MAX  = 256,
  parameter logic [7:0]  DELIM     = DELIM_DEFAULT,
  parameter int unsigned BEGIN_MIN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       body_valid,
  output logic       body_ready,
  input  logic [7:0] body_data,
  input  logic       body_last,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [7:0] dout,
  output logic       busy,
  output logic       err_overflow,
  output logic       err_format
);

  localparam int unsigned AW      = (BODY_MAX > 1) ? $clog2(BODY_MAX) : 1;
  localparam logic [9:0]  LEN_MAX = 10'(BODY_MAX);

  fix_state_t state, state_n;
  logic [9:0] len, idx, idx_n;
  logic [7:0] cks;
  logic       dropping, rdy_q;
  logic       acc, xfer, mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem [BODY_MAX];
  logic [7:0] rd_data;
  logic [9:0] b2d_in;
  logic [3:0] d2, d1, d0, digit;
  logic [1:0] ndig, ndig_eff, kk, pos;

  fix_bin2dec u_b2d (
    .value(b2d_in),
    .d2   (d2),
    .d1   (d1),
    .d0   (d0),
    .ndig (ndig)
  );

  assign acc  = body_valid && body_ready;
  assign xfer = dout_valid && dout_ready;

  // Read address runs one byte ahead on each BODY transfer so rd_data is ready next cycle.
  always_comb begin
    mem_we   = (state == S_LOAD) && acc && !dropping && (len < LEN_MAX)
               && !(body_last && (body_data != DELIM));
    mem_addr = '0;
    if (state == S_LOAD)
      mem_addr = len;
    else if (state == S_BODY)
      mem_addr = xfer ? (idx + 10'd1) : idx;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr[AW-1:0]] <= body_data;
    rd_data <= (mem_addr < LEN_MAX) ? mem[mem_addr[AW-1:0]] : '0;
  end

  always_comb begin
    b2d_in   = (state == S_CKS) ? {2'b00, cks} : len;
    ndig_eff = (state == S_CKS) ? 2'd3 : ndig;
    kk       = (state == S_CKS) ? idx[1:0] : 2'(idx - 10'd2);
    pos      = kk + (2'd3 - ndig_eff);
    digit    = (pos == 2'd0) ? d2 : ((pos == 2'd1) ? d1 : d0);
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    dout       = '0;
    dout_valid = (state != S_LOAD);
    busy       = (state != S_LOAD);
    body_ready = rdy_q && (state == S_LOAD);
    case (state)
      S_LOAD: begin
        if (acc && !dropping && (len < LEN_MAX) && body_last && (body_data == DELIM)) begin
          state_n = S_HDR;
          idx_n   = '0;
        end
      end
      S_HDR: begin
        dout = hdr_byte(idx[3:0], 4'(BEGIN_MIN), DELIM);
        if (xfer) begin
          idx_n = idx + 10'd1;
          if (idx == 10'(HDR_LEN - 1)) begin
            state_n = S_LEN;
            idx_n   = '0;
          end
        end
      end
      S_LEN: begin
        dout = (idx == 10'd0) ? ASC_9 : ((idx == 10'd1) ? ASC_EQ : {4'h3, digit});
        if (xfer) begin
          idx_n = idx + 10'd1;
          if (idx == (10'(ndig) + 10'd1)) begin
            state_n = S_LDLM;
            idx_n   = '0;
          end
        end
      end
      S_LDLM: begin
        dout = DELIM;
        if (xfer) begin
          state_n = S_BODY;
          idx_n   = '0;
        end
      end
      S_BODY: begin
        dout = rd_data;
        if (xfer) begin
          idx_n = idx + 10'd1;
          if (idx == (len - 10'd1)) begin
            state_n = S_TRL;
            idx_n   = '0;
          end
        end
      end
      S_TRL: begin
        dout = (idx == 10'd0) ? ASC_1 : ((idx == 10'd1) ? ASC_0 : ASC_EQ);
        if (xfer) begin
          idx_n = idx + 10'd1;
          if (idx == 10'd2) begin
            state_n = S_CKS;
            idx_n   = '0;
          end
        end
      end
      S_CKS: begin
        dout = {4'h3, digit};
        if (xfer) begin
          idx_n = idx + 10'd1;
          if (idx == 10'd2) begin
            state_n = S_TDLM;
            idx_n   = '0;
          end
        end
      end
      S_TDLM: begin
        dout = DELIM;
        if (xfer) begin
          state_n = S_LOAD;
          idx_n   = '0;
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LOAD;
      idx          <= '0;
      len          <= '0;
      cks          <= '0;
      dropping     <= 1'b0;
      rdy_q        <= 1'b0;
      err_overflow <= 1'b0;
      err_format   <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      rdy_q        <= 1'b1;
      err_overflow <= 1'b0;
      err_format   <= 1'b0;
      if (state == S_LOAD) begin
        cks <= '0;
        if (acc) begin
          if (dropping) begin
            if (body_last) begin
              dropping <= 1'b0;
              len      <= '0;
            end
          end else if (len == LEN_MAX) begin
            err_overflow <= 1'b1;
            if (body_last) len <= '0;
            else           dropping <= 1'b1;
          end else if (body_last && (body_data != DELIM)) begin
            err_format <= 1'b1;
            len        <= '0;
          end else begin
            len <= len + 10'd1;
          end
        end
      end else if (xfer && (state inside {S_HDR, S_LEN, S_LDLM, S_BODY})) begin
        cks <= cks + dout;
      end
      if ((state == S_TDLM) && xfer)
        len <= '0;
    end
  end

endmodule

// File: tb/tb_fix_msg_tx.sv
// Self-checking bench for fix_msg_tx against a string-level model of the FIX frame.
module tb_fix_msg_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, bv, blast, dr, sel;
  logic [7:0] bdata;
  logic       br_a, dv_a, busy_a, eo_a, ef_a;
  logic       br_b, dv_b, busy_b, eo_b, ef_b;
  logic [7:0] do_a, do_b;
  logic       o_br, o_dv, o_busy;
  logic [7:0] o_do;

  int n_assert = 0, n_fail = 0;
  int ovf_a = 0, ovf_b = 0, fmt_a = 0, fmt_b = 0, vcnt_a = 0, vcnt_b = 0;

  logic [7:0] body_q[$], exp_q[$], rx[$];

  fix_msg_tx dut_a (
    .clk(clk), .reset(reset), .body_valid(bv & ~sel), .body_ready(br_a),
    .body_data(bdata), .body_last(blast), .dout_valid(dv_a), .dout_ready(dr),
    .dout(do_a), .busy(busy_a), .err_overflow(eo_a), .err_format(ef_a)
  );

  fix_msg_tx #(.BODY_MAX(8)) dut_b (
    .clk(clk), .reset(reset), .body_valid(bv & sel), .body_ready(br_b),
    .body_data(bdata), .body_last(blast), .dout_valid(dv_b), .dout_ready(dr),
    .dout(do_b), .busy(busy_b), .err_overflow(eo_b), .err_format(ef_b)
  );

  assign o_br   = sel ? br_b : br_a;
  assign o_dv   = sel ? dv_b : dv_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_do   = sel ? do_b : do_a;

  always @(negedge clk) begin
    ovf_a  += int'(eo_a);
    ovf_b  += int'(eo_b);
    fmt_a  += int'(ef_a);
    fmt_b  += int'(ef_b);
    vcnt_a += int'(dv_a);
    vcnt_b += int'(dv_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_body(input string s);
    body_q.delete();
    for (int i = 0; i < s.len(); i++) body_q.push_back(s[i]);
  endtask

  // Reference frame: header, decimal length, body, then "10=" and a 3-digit byte sum.
  task automatic build();
    string s;
    int    sum;
    exp_q.delete();
    s = $sformatf("8=FIX.4.4;9=%0d;", body_q.size());
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    foreach (body_q[i]) exp_q.push_back(body_q[i]);
    sum = 0;
    foreach (exp_q[i]) sum += int'(exp_q[i]);
    s = $sformatf("10=%03d;", sum % 256);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic send_body(input logic s);
    int w;
    sel = s;
    #1;
    foreach (body_q[i]) begin
      bv    = 1'b1;
      bdata = body_q[i];
      blast = (i == body_q.size() - 1);
      w = 0;
      while (!o_br && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) check("body_ready wait", o_br, 1);
      @(negedge clk);
    end
    bv    = 1'b0;
    blast = 1'b0;
  endtask

  // mode 0: ready always; 1: one cycle on, two off; 2: random. nstop>0 stops after nstop bytes.
  task automatic run_frame(input int mode, input int nstop, input string tag);
    int         cyc, first, last_x, stop;
    logic       pstall;
    logic [7:0] pd;
    rx.delete();
    stop   = (nstop > 0) ? nstop : exp_q.size();
    cyc    = 0;
    first  = -1;
    last_x = -1;
    pstall = 1'b0;
    pd     = '0;
    while (cyc < 3000) begin
      case (mode)
        0:       dr = 1'b1;
        1:       dr = ((cyc % 3) == 0);
        default: dr = 1'($urandom_range(0, 1));
      endcase
      if (pstall) begin
        check({tag, " stall valid"}, o_dv, 1);
        check({tag, " stall data"}, o_do, pd);
      end
      if (o_dv && first < 0) first = cyc;
      if (o_dv && dr) begin
        rx.push_back(o_do);
        last_x = cyc;
      end
      pstall = o_dv && !dr;
      pd     = o_do;
      @(negedge clk);
      cyc++;
      if (rx.size() >= stop) break;
    end
    dr = 1'b1;
    check({tag, " byte count"}, rx.size(), stop);
    for (int i = 0; i < rx.size() && i < stop; i++)
      check($sformatf("%s byte%0d", tag, i), rx[i], exp_q[i]);
    if (nstop == 0) begin
      if (mode == 0) check({tag, " no gaps"}, last_x - first + 1, exp_q.size());
      check({tag, " valid after frame"}, o_dv, 0);
      check({tag, " busy after frame"}, o_busy, 0);
    end
  endtask

  initial begin
    int ov0, v0, f0, n;
    reset = 1'b1;
    bv    = 1'b0;
    blast = 1'b0;
    bdata = '0;
    dr    = 1'b0;
    sel   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset body_ready", o_br, 0);
    check("reset dout_valid", o_dv, 0);
    check("reset dout", o_do, 0);
    check("reset busy", o_busy, 0);
    check("reset err_overflow", eo_a, 0);
    check("reset err_format", ef_a, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset body_ready", o_br, 1);

    // heartbeat frame, continuous ready
    set_body("35=0;");
    build();
    dr = 1'b1;
    send_body(0);
    check("c1 busy", o_busy, 1);
    run_frame(0, 0, "c1");

    // 100-byte body: three-digit length
    set_body("35=A;");
    repeat (94) body_q.push_back(8'h31);
    body_q.push_back(8'h3b);
    build();
    send_body(0);
    run_frame(0, 0, "c2");

    // back-pressure 1 on / 2 off
    set_body("35=0;");
    build();
    send_body(0);
    run_frame(1, 0, "c3");

    // overflow on the BODY_MAX=8 instance: 9 bytes, then 13 bytes
    ov0 = ovf_b;
    v0  = vcnt_b;
    set_body("35=00000;");
    send_body(1);
    repeat (3) @(negedge clk);
    check("c4 overflow pulses", ovf_b - ov0, 1);
    check("c4 no output", vcnt_b - v0, 0);
    check("c4 body_ready", o_br, 1);
    ov0 = ovf_b;
    set_body("35=000000000;");
    send_body(1);
    repeat (3) @(negedge clk);
    check("c4 long overflow pulses", ovf_b - ov0, 1);
    check("c4 long no output", vcnt_b - v0, 0);
    set_body("35=0;");
    build();
    send_body(1);
    run_frame(0, 0, "c4 recover");

    // bad terminator
    f0 = fmt_a;
    v0 = vcnt_a;
    set_body("35=0X");
    send_body(0);
    repeat (3) @(negedge clk);
    check("c5 format pulses", fmt_a - f0, 1);
    check("c5 no output", vcnt_a - v0, 0);
    check("c5 body_ready", o_br, 1);

    // reset mid-frame
    set_body("35=0;");
    build();
    send_body(0);
    run_frame(0, 12, "c6 partial");
    reset = 1'b1;
    @(negedge clk);
    check("c6 valid in reset", o_dv, 0);
    check("c6 busy in reset", o_busy, 0);
    check("c6 body_ready in reset", o_br, 0);
    reset = 1'b0;
    @(negedge clk);
    check("c6 body_ready after", o_br, 1);
    send_body(0);
    run_frame(0, 0, "c6 resend");

    // length boundaries then random bodies, random back-pressure
    for (int it = 0; it < 7; it++) begin
      case (it)
        0:       n = 1;
        1:       n = 9;
        2:       n = 10;
        3:       n = 99;
        default: n = int'($urandom_range(2, 200));
      endcase
      body_q.delete();
      for (int k = 0; k < n - 1; k++) body_q.push_back(8'(8'h20 + $urandom_range(0, 94)));
      body_q.push_back(8'h3b);
      build();
      send_body(0);
      run_frame(2, 0, $sformatf("rand%0d len%0d", it, n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
